// File: rtl/rr_dec_pkg.sv
// Shared constants and state type for the 16-way round-robin decoded arbiter.
// Optional hold timeout in rr_dec_arbiter is enabled by RR_DEC_ARBITER_TIMEOUT_EN.
package rr_dec_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_dec4x16.sv
// Enabled 4-to-16 one-hot decoder; output is all zero while en is low.
// Part of rr_dec_arbiter (optional timeout macro RR_DEC_ARBITER_TIMEOUT_EN does not affect it).
module onehot_dec4x16 (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_dec_arbiter.sv
// 16-requester round-robin arbiter with registered winner index and one-hot decoded grant.
// Define RR_DEC_ARBITER_TIMEOUT_EN to bound each grant to HOLD_MAX cycles.
//
//   state | meaning
//   IDLE  | no grant; arbitrate from ptr on any request
//   GRANT | gnt_idx owns the resource until done, request drop or timeout
module rr_dec_arbiter
    import rr_dec_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    if (HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_hold_range_check
        $error("rr_dec_arbiter: HOLD_MAX must be in 1..65535");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             any_req;
    logic             release_req;

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
    logic [15:0] hold_q, hold_d;
    logic        timeout_q, timeout_d;
`endif

    // Rotating priority: first set request at ptr, ptr+1, ... wrapping through 15 to 0.
    always_comb begin
        pick    = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!any_req && req_i[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    assign release_req = done_i || !req_i[idx_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = pick;
                    state_d = GRANT;
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (release_req) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 1'b1;
                end
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
                // A normal release on the same cycle wins, so timeout only fires here.
                else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    ptr_d     = idx_q + 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_idx_o   = idx_q;

    onehot_dec4x16 u_dec (
        .en  (gnt_valid_o),
        .sel (idx_q),
        .y   (gnt_o)
    );

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Self-checking bench for rr_dec_arbiter: directed vector table, corner sequences and random traffic vs a reference model.
// Timeout checks are active when RR_DEC_ARBITER_TIMEOUT_EN is defined (HOLD_MAX set to 4).
module tb_rr_dec_arbiter;

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
    localparam int HOLD  = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int HOLD  = 64;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    // Reference model state: busy flag, grantee, next search start, cycles held.
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_cyc;
    bit m_to;

    rr_dec_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic [15:0] gnt;
        logic        valid;
        logic [3:0]  idx;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_cyc  = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_edge(input logic [15:0] r, input logic d);
        m_to = 1'b0;
        if (m_busy) begin
            if (d || !r[m_idx]) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 16;
            end else if (TO_EN && (m_cyc + 1 == HOLD)) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 16;
                m_to   = 1'b1;
            end else begin
                m_cyc++;
            end
        end else if (r != 16'h0000) begin
            for (int k = 0; k < 16; k++) begin
                if (r[(m_ptr + k) % 16]) begin
                    m_idx = (m_ptr + k) % 16;
                    break;
                end
            end
            m_busy = 1'b1;
            m_cyc  = 0;
        end
    endtask

    task automatic step(input logic [15:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [15:0] exp_gnt;
        exp_gnt = m_busy ? (16'h0001 << m_idx) : 16'h0000;
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_busy));
        chk({tag, "_idx"}, 32'(gnt_idx), 32'(m_idx));
        chk({tag, "_timeout"}, 32'(timeout), 32'(m_to));
        chk({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    initial begin
        logic [15:0] pend;
        logic        d;
        bit          was_busy;
        int          widx;

        //          req       done   gnt       valid idx
        vecs[0]  = '{16'h0020, 1'b0, 16'h0020, 1'b1, 4'd5};
        vecs[1]  = '{16'h0020, 1'b0, 16'h0020, 1'b1, 4'd5};
        vecs[2]  = '{16'h0020, 1'b1, 16'h0000, 1'b0, 4'd5};
        vecs[3]  = '{16'h8001, 1'b0, 16'h8000, 1'b1, 4'd15};
        vecs[4]  = '{16'h8001, 1'b1, 16'h0000, 1'b0, 4'd15};
        vecs[5]  = '{16'h8001, 1'b0, 16'h0001, 1'b1, 4'd0};
        vecs[6]  = '{16'h8001, 1'b1, 16'h0000, 1'b0, 4'd0};
        vecs[7]  = '{16'h8001, 1'b0, 16'h8000, 1'b1, 4'd15};
        vecs[8]  = '{16'h8001, 1'b1, 16'h0000, 1'b0, 4'd15};
        vecs[9]  = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'd15};
        vecs[10] = '{16'h0004, 1'b0, 16'h0004, 1'b1, 4'd2};
        vecs[11] = '{16'h0005, 1'b0, 16'h0004, 1'b1, 4'd2};
        vecs[12] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 4'd2};
        vecs[13] = '{16'h0005, 1'b0, 16'h0001, 1'b1, 4'd0};
        vecs[14] = '{16'h0005, 1'b1, 16'h0000, 1'b0, 4'd0};
        vecs[15] = '{16'h0005, 1'b0, 16'h0004, 1'b1, 4'd2};
        vecs[16] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'd2};

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            step(16'h0000, 1'b0);
            check_model("idle");
            chk("idle_gnt_const", 32'(gnt), 32'h0);
            chk("idle_idx_const", 32'(gnt_idx), 32'h0);
        end

        for (int v = 0; v < 17; v++) begin
            step(vecs[v].req, vecs[v].done);
            chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].gnt));
            chk($sformatf("vec%0d_valid", v), 32'(gnt_valid), 32'(vecs[v].valid));
            chk($sformatf("vec%0d_idx", v), 32'(gnt_idx), 32'(vecs[v].idx));
            chk($sformatf("vec%0d_timeout", v), 32'(timeout), 32'h0);
        end

        // Asynchronous reset while idx 7 holds the grant.
        step(16'h0080, 1'b0);
        chk("ar_pre_gnt", 32'(gnt), 32'h0080);
        chk("ar_pre_idx", 32'(gnt_idx), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_valid", 32'(gnt_valid), 32'h0);
        chk("ar_idx", 32'(gnt_idx), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0081, 1'b0);
        chk("ar_restart_gnt", 32'(gnt), 32'h0001);
        chk("ar_restart_idx", 32'(gnt_idx), 32'd0);
        step(16'h0000, 1'b1);
        check_model("ar_release");

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
        // Held request with no done: four grant cycles, forced release, one idle cycle, re-grant.
        for (int c = 0; c < 4; c++) begin
            step(16'h0008, 1'b0);
            chk($sformatf("to_hold%0d_gnt", c), 32'(gnt), 32'h0008);
            chk($sformatf("to_hold%0d_timeout", c), 32'(timeout), 32'h0);
        end
        step(16'h0008, 1'b0);
        chk("to_fire_gnt", 32'(gnt), 32'h0);
        chk("to_fire_timeout", 32'(timeout), 32'h1);
        chk("to_fire_valid", 32'(gnt_valid), 32'h0);
        step(16'h0008, 1'b0);
        chk("to_regrant_gnt", 32'(gnt), 32'h0008);
        chk("to_regrant_timeout", 32'(timeout), 32'h0);
        step(16'h0008, 1'b1);
        check_model("to_done");
`endif

        pend = '0;
        for (int n = 0; n < 3000; n++) begin
            pend = pend | 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) pend = pend & 16'($urandom);
            d        = ($urandom_range(0, 5) == 0);
            was_busy = m_busy;
            widx     = m_idx;
            step(pend, d);
            check_model("rand");
            if (was_busy && !m_busy && d) pend[widx] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
